// File: rtl/lc_pkg.sv
// Shared definitions for the layout-converter unpacker: widths, FSM states, instruction layout.
package lc_pkg;

  localparam int unsigned AXI_DATA_WIDTH   = 128;
  localparam int unsigned PE_DATA_WIDTH    = 64;
  localparam int unsigned CORE_INSTR_WIDTH = 64;
  localparam int unsigned RATIO            = AXI_DATA_WIDTH / PE_DATA_WIDTH;
  localparam int unsigned LANE_W           = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned KEEP_W           = PE_DATA_WIDTH / 8;

  // Instruction field layout: word count N at [15:0], first lane L at [23:16].
  localparam int unsigned CNT_LSB    = 0;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned LANE_LSB   = CNT_LSB + CNT_W;
  localparam int unsigned LANE_FLD_W = 8;
  localparam int unsigned RSVD_W     = CORE_INSTR_WIDTH - (LANE_LSB + LANE_FLD_W);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_FETCH = 2'd1,
    S_RUN   = 2'd2
  } lc_state_e;

  typedef struct packed {
    logic [RSVD_W-1:0]     rsvd;
    logic [LANE_FLD_W-1:0] first_lane;
    logic [CNT_W-1:0]      count;
  } lc_instr_t;

  // Starting lane for an instruction; out-of-range lanes wrap modulo RATIO.
  function automatic logic [LANE_W-1:0] start_lane(input logic [LANE_FLD_W-1:0] l);
    return LANE_W'(32'(l) % RATIO);
  endfunction

endpackage

// File: rtl/dbus_unpacker_if.sv
// Stream bundle of the unpacker: instruction in, data-bus beats in, PE words out.
interface dbus_unpacker_if;
  import lc_pkg::*;

  logic                        s_axis_instr_tready;
  logic                        s_axis_instr_tvalid;
  logic [CORE_INSTR_WIDTH-1:0] s_axis_instr_tdata;

  logic                        s_axis_dbus_tready;
  logic                        s_axis_dbus_tvalid;
  logic [AXI_DATA_WIDTH-1:0]   s_axis_dbus_tdata;
  logic                        s_axis_dbus_tlast;

  logic                        m_axis_pe_tready;
  logic                        m_axis_pe_tvalid;
  logic [PE_DATA_WIDTH-1:0]    m_axis_pe_tdata;
  logic [KEEP_W-1:0]           m_axis_pe_tkeep;
  logic                        m_axis_pe_tlast;

  // Unpacker side
  modport slave (
    output s_axis_instr_tready,
    input  s_axis_instr_tvalid, s_axis_instr_tdata,
    output s_axis_dbus_tready,
    input  s_axis_dbus_tvalid, s_axis_dbus_tdata, s_axis_dbus_tlast,
    input  m_axis_pe_tready,
    output m_axis_pe_tvalid, m_axis_pe_tdata, m_axis_pe_tkeep, m_axis_pe_tlast
  );

  // Environment side
  modport master (
    input  s_axis_instr_tready,
    output s_axis_instr_tvalid, s_axis_instr_tdata,
    input  s_axis_dbus_tready,
    output s_axis_dbus_tvalid, s_axis_dbus_tdata, s_axis_dbus_tlast,
    output m_axis_pe_tready,
    input  m_axis_pe_tvalid, m_axis_pe_tdata, m_axis_pe_tkeep, m_axis_pe_tlast
  );

endinterface

// File: rtl/dbus_unpacker_lane_mux.sv
// RATIO-way selector picking one PE_DATA_WIDTH lane out of a data-bus beat.
module dbus_unpacker_lane_mux
  import lc_pkg::*;
(
  input  logic [AXI_DATA_WIDTH-1:0] data_i,
  input  logic [LANE_W-1:0]         sel_i,
  output logic [PE_DATA_WIDTH-1:0]  data_o
);

  // One-hot compare per lane; unselected encodings yield zero
  always_comb begin
    data_o = '0;
    for (int i = 0; i < int'(RATIO); i++) begin
      if (sel_i == LANE_W'(i)) begin
        data_o = data_i[i*PE_DATA_WIDTH +: PE_DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/dbus_unpacker.sv
// Instruction-driven width down-converter: slices data-bus beats into PE words.
// Optional short-burst detection is enabled by defining LC_UNPACK_TLAST_CHECK_EN.
module dbus_unpacker
  import lc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ap_start,
  dbus_unpacker_if.slave  bus,
  output logic            err
);

  lc_state_e                 state_q, state_d;
  logic                      start_q;
  logic [AXI_DATA_WIDTH-1:0] buf_q, buf_d;
  logic                      buf_valid_q, buf_valid_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [LANE_W-1:0]         lane_q, lane_d;

  lc_instr_t                 instr;
  logic                      out_valid;
  logic                      out_fire;
  logic                      last_word;
  logic                      lane_end;
  logic                      short_burst;
  logic                      end_instr;
  logic                      in_ready;
  logic                      in_fire;
  logic                      instr_ready;
  logic [PE_DATA_WIDTH-1:0]  lane_data;

  assign instr = lc_instr_t'(bus.s_axis_instr_tdata);

`ifdef LC_UNPACK_TLAST_CHECK_EN
  logic buf_last_q, buf_last_d;
  logic err_q, err_d;
  logic unused_bits;
  assign unused_bits = ^instr.rsvd;

  // Burst ended before the instruction was satisfied
  assign short_burst = buf_last_q & lane_end & ~last_word;
`else
  logic unused_bits;
  assign unused_bits = ^{instr.rsvd, bus.s_axis_dbus_tlast};
  assign short_burst = 1'b0;
`endif

  assign out_valid = (state_q == S_RUN) & buf_valid_q;
  assign out_fire  = out_valid & bus.m_axis_pe_tready;
  assign last_word = (cnt_q == CNT_W'(1));
  assign lane_end  = (lane_q == LANE_W'(RATIO - 1));
  assign end_instr = last_word | short_burst;

  // A new beat is taken into an empty buffer, or into one being drained of its
  // last lane mid-instruction; never once the instruction is finishing.
  assign in_ready = (state_q == S_RUN) &
                    (~buf_valid_q | (out_fire & lane_end & ~end_instr));
  assign in_fire  = in_ready & bus.s_axis_dbus_tvalid;

  // Sticky start latch, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
    end else if (ap_start) begin
      start_q <= 1'b1;
    end
  end

  // State, counter, lane and holding-buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_WAIT;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      cnt_q       <= '0;
      lane_q      <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
    end
  end

  // Next-state: instruction fetch, word emission and beat refill
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    instr_ready = 1'b0;

    case (state_q)
      S_WAIT: begin
        if (start_q) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        instr_ready = 1'b1;
        buf_valid_d = 1'b0;
        if (bus.s_axis_instr_tvalid) begin
          cnt_d  = instr.count;
          lane_d = start_lane(instr.first_lane);
          // A zero-count instruction is consumed without leaving fetch
          if (instr.count != '0) begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (out_fire) begin
          cnt_d  = cnt_q - 1'b1;
          lane_d = lane_end ? '0 : lane_q + 1'b1;
          if (lane_end || end_instr) begin
            buf_valid_d = 1'b0;
          end
          if (end_instr) begin
            state_d = S_FETCH;
          end
        end
        if (in_fire) begin
          buf_d       = bus.s_axis_dbus_tdata;
          buf_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

`ifdef LC_UNPACK_TLAST_CHECK_EN
  // Burst-end marker of the held beat, and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_last_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      buf_last_q <= buf_last_d;
      err_q      <= err_d;
    end
  end

  // Capture burst end with each beat; raise error on premature termination
  always_comb begin
    buf_last_d = buf_last_q;
    err_d      = err_q;
    if (in_fire) begin
      buf_last_d = bus.s_axis_dbus_tlast;
    end
    if (out_fire && short_burst) begin
      err_d = 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  dbus_unpacker_lane_mux u_lane_mux (
    .data_i (buf_q),
    .sel_i  (lane_q),
    .data_o (lane_data)
  );

  // Stream outputs derived from registered state
  assign bus.s_axis_instr_tready = instr_ready;
  assign bus.s_axis_dbus_tready  = in_ready;
  assign bus.m_axis_pe_tvalid    = out_valid;
  assign bus.m_axis_pe_tdata     = lane_data;
  assign bus.m_axis_pe_tkeep     = out_valid ? {KEEP_W{1'b1}} : {KEEP_W{1'b0}};
  assign bus.m_axis_pe_tlast     = out_valid & end_instr;

endmodule

// File: tb/tb_dbus_unpacker.sv
// Randomized bench for dbus_unpacker with a queue-based reference model.
module tb_dbus_unpacker;
  import lc_pkg::*;

  typedef struct {
    logic [PE_DATA_WIDTH-1:0] d;
    logic                     l;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ap_start;
  logic err;

  always #5 clk = ~clk;

  dbus_unpacker_if bus ();

  dbus_unpacker dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ap_start (ap_start),
    .bus      (bus),
    .err      (err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  exp_t                      exp_q[$];
  logic [CORE_INSTR_WIDTH-1:0] instr_q[$];
  logic [AXI_DATA_WIDTH:0]   beat_q[$];
  int                        out_cyc[$];

  bit   mon_en   = 1'b0;
  bit   sink_rnd = 1'b0;
  bit   sink_on  = 1'b0;
  bit   src_rnd  = 1'b0;
  logic exp_err  = 1'b0;

  logic                     stall_q = 1'b0;
  logic [PE_DATA_WIDTH-1:0] held_data;
  logic                     held_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: words of an instruction, beats it needs, burst-end rule
  task automatic add_instr(input int n, input int l, input bit tl_en);
    int   rem;
    int   lane;
    logic tl;
    logic [AXI_DATA_WIDTH-1:0] b;
    exp_t e;
    instr_q.push_back({8'($urandom), 32'($urandom), 8'(l), 16'(n)});
    rem  = n;
    lane = l % int'(RATIO);
    while (rem > 0) begin
      for (int k = 0; k < int'(AXI_DATA_WIDTH / 32); k++) b[k*32 +: 32] = $urandom;
      tl = tl_en && (($urandom % 4) == 0);
      beat_q.push_back({tl, b});
      for (int ln = lane; ln < int'(RATIO) && rem > 0; ln++) begin
        e.d = b[ln*PE_DATA_WIDTH +: PE_DATA_WIDTH];
        e.l = (rem == 1);
`ifdef LC_UNPACK_TLAST_CHECK_EN
        if (tl && ln == int'(RATIO) - 1 && rem > 1) begin
          e.l     = 1'b1;
          rem     = 1;
          exp_err = 1'b1;
        end
`endif
        exp_q.push_back(e);
        rem--;
      end
      lane = 0;
    end
  endtask

  task automatic drive_instrs();
    int k;
    while (instr_q.size() > 0) begin
      repeat (src_rnd ? $urandom_range(0, 2) : 0) begin @(posedge clk); #1; end
      bus.s_axis_instr_tvalid = 1'b1;
      bus.s_axis_instr_tdata  = instr_q.pop_front();
      for (k = 0; k < 2000; k++) begin
        @(negedge clk);
        if (bus.s_axis_instr_tready) break;
      end
      if (k == 2000) instr_q.delete();
      @(posedge clk); #1;
      bus.s_axis_instr_tvalid = 1'b0;
      bus.s_axis_instr_tdata  = CORE_INSTR_WIDTH'($urandom);
    end
  endtask

  task automatic drive_beats();
    int k;
    logic [AXI_DATA_WIDTH:0] bt;
    while (beat_q.size() > 0) begin
      repeat (src_rnd ? $urandom_range(0, 2) : 0) begin @(posedge clk); #1; end
      bt = beat_q.pop_front();
      bus.s_axis_dbus_tvalid = 1'b1;
      bus.s_axis_dbus_tdata  = bt[AXI_DATA_WIDTH-1:0];
      bus.s_axis_dbus_tlast  = bt[AXI_DATA_WIDTH];
      for (k = 0; k < 2000; k++) begin
        @(negedge clk);
        if (bus.s_axis_dbus_tready) break;
      end
      if (k == 2000) beat_q.delete();
      @(posedge clk); #1;
      bus.s_axis_dbus_tvalid = 1'b0;
      bus.s_axis_dbus_tlast  = 1'b0;
    end
  endtask

  task automatic run_phase();
    int k;
    fork
      drive_instrs();
      drive_beats();
    join
    for (k = 0; k < 3000 && exp_q.size() > 0; k++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check_eq("drain_left", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
  endtask

  // Output sink with optional random backpressure
  initial begin
    bus.m_axis_pe_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.m_axis_pe_tready = sink_rnd ? (($urandom % 3) != 0) : sink_on;
    end
  end

  // Output monitor: ordering, content, tlast, tkeep and hold-while-stalled
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst_n) begin
      if (bus.m_axis_pe_tvalid) check_eq("tkeep", 128'(bus.m_axis_pe_tkeep), 128'({KEEP_W{1'b1}}));
      if (stall_q) begin
        check_eq("hold_valid", 128'(bus.m_axis_pe_tvalid), 128'(1));
        check_eq("hold_data", 128'(bus.m_axis_pe_tdata), 128'(held_data));
        check_eq("hold_last", 128'(bus.m_axis_pe_tlast), 128'(held_last));
      end
      if (bus.m_axis_pe_tvalid && bus.m_axis_pe_tready) begin
        out_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check_eq("extra_word", 128'(bus.m_axis_pe_tdata), 128'(0) - 128'(1));
        end else begin
          e = exp_q.pop_front();
          check_eq("word_data", 128'(bus.m_axis_pe_tdata), 128'(e.d));
          check_eq("word_last", 128'(bus.m_axis_pe_tlast), 128'(e.l));
        end
      end
      stall_q   <= bus.m_axis_pe_tvalid && !bus.m_axis_pe_tready;
      held_data <= bus.m_axis_pe_tdata;
      held_last <= bus.m_axis_pe_tlast;
    end else begin
      stall_q <= 1'b0;
    end
  end

  initial begin
    int k;
    rst_n                   = 1'b0;
    ap_start                = 1'b0;
    bus.s_axis_instr_tvalid = 1'b0;
    bus.s_axis_instr_tdata  = '0;
    bus.s_axis_dbus_tvalid  = 1'b0;
    bus.s_axis_dbus_tdata   = '0;
    bus.s_axis_dbus_tlast   = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    check_eq("rst_instr_rdy", 128'(bus.s_axis_instr_tready), 128'(0));
    check_eq("rst_dbus_rdy", 128'(bus.s_axis_dbus_tready), 128'(0));
    check_eq("rst_valid", 128'(bus.m_axis_pe_tvalid), 128'(0));
    check_eq("rst_tlast", 128'(bus.m_axis_pe_tlast), 128'(0));
    check_eq("rst_tkeep", 128'(bus.m_axis_pe_tkeep), 128'(0));
    check_eq("rst_tdata", 128'(bus.m_axis_pe_tdata), 128'(0));
    check_eq("rst_err", 128'(err), 128'(0));

    // No handshakes before ap_start
    rst_n                   = 1'b1;
    sink_on                 = 1'b1;
    bus.s_axis_instr_tvalid = 1'b1;
    bus.s_axis_instr_tdata  = 64'd2;
    bus.s_axis_dbus_tvalid  = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("gate_instr_rdy", 128'(bus.s_axis_instr_tready), 128'(0));
      check_eq("gate_dbus_rdy", 128'(bus.s_axis_dbus_tready), 128'(0));
    end
    @(posedge clk); #1;
    bus.s_axis_instr_tvalid = 1'b0;
    bus.s_axis_dbus_tvalid  = 1'b0;
    ap_start = 1'b1;
    @(posedge clk); #1;
    ap_start = 1'b0;

    // Basic run with everything ready: back-to-back words
    mon_en = 1'b1;
    out_cyc.delete();
    add_instr(4, 0, 1'b0);
    run_phase();
    check_eq("thru_count", 128'(out_cyc.size()), 128'(4));
    if (out_cyc.size() == 4) check_eq("thru_b2b", 128'(out_cyc[3] - out_cyc[0]), 128'(3));

    // Lane offset, remainder drop, zero count, L wrap
    add_instr(3, 1, 1'b0);
    add_instr(1, 0, 1'b0);
    add_instr(0, 0, 1'b0);
    add_instr(2, 0, 1'b0);
    add_instr(5, 7, 1'b0);
    add_instr(1, 1, 1'b0);
    run_phase();

    // Random traffic with source gaps, sink backpressure and burst ends
    sink_rnd = 1'b1;
    src_rnd  = 1'b1;
    repeat (6) begin
      for (int i = 0; i < 8; i++) add_instr($urandom_range(0, 9), $urandom_range(0, 5), 1'b1);
      run_phase();
    end
    add_instr(300, 1, 1'b0);
    run_phase();
    check_eq("err_flag", 128'(err), 128'(exp_err));

    // Asynchronous reset in the middle of a run
    mon_en   = 1'b0;
    sink_rnd = 1'b0;
    sink_on  = 1'b0;
    @(posedge clk); #1;
    bus.s_axis_instr_tvalid = 1'b1;
    bus.s_axis_instr_tdata  = 64'd8;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.s_axis_instr_tready) break;
    end
    @(posedge clk); #1;
    bus.s_axis_instr_tvalid = 1'b0;
    bus.s_axis_dbus_tvalid  = 1'b1;
    bus.s_axis_dbus_tdata   = {$urandom, $urandom, $urandom, $urandom};
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.m_axis_pe_tvalid) break;
    end
    bus.s_axis_dbus_tvalid = 1'b0;
    check_eq("pre_rst_valid", 128'(bus.m_axis_pe_tvalid), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 128'(bus.m_axis_pe_tvalid), 128'(0));
    check_eq("arst_dbus_rdy", 128'(bus.s_axis_dbus_tready), 128'(0));
    check_eq("arst_instr_rdy", 128'(bus.s_axis_instr_tready), 128'(0));
    check_eq("arst_err", 128'(err), 128'(0));
    exp_err = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Start latch was cleared: no fetch until a new ap_start
    bus.s_axis_instr_tvalid = 1'b1;
    bus.s_axis_instr_tdata  = 64'd2;
    repeat (4) begin
      @(negedge clk);
      check_eq("post_rst_gate", 128'(bus.s_axis_instr_tready), 128'(0));
    end
    @(posedge clk); #1;
    bus.s_axis_instr_tvalid = 1'b0;
    ap_start = 1'b1;
    @(posedge clk); #1;
    ap_start = 1'b0;

    mon_en  = 1'b1;
    sink_on = 1'b1;
    src_rnd = 1'b0;
    add_instr(2, 1, 1'b0);
    add_instr(3, 0, 1'b0);
    run_phase();
    check_eq("err_final", 128'(err), 128'(exp_err));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
